// File: rtl/pipelined_adder.sv
// Pipelined N-bit add/subtract unit with ready/valid flow control on both sides.
// Operands are cut into STAGES chunks; each stage adds one chunk plus the carry
// rippled from the previous stage, so the critical path is one CHUNK-bit adder.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a/b/sub/cin carry a valid operation
//   in_ready   an operation is accepted this cycle
//   a, b       N-bit operands
//   sub        0: a+b+cin, 1: a-b (cin ignored)
//   cin        carry-in for add mode
//   out_valid  sum/ovf hold a valid result
//   out_ready  downstream accepts the result
//   sum        N+1-bit result (bit N is carry in add mode, borrow in sub mode)
//   ovf        signed overflow of the N-bit two's-complement result
module pipelined_adder #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   sum,
    output logic         ovf
);

    localparam int C  = N / STAGES;
    localparam int CW = C + 1;

    generate
        if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
            $error("pipelined_adder: N must be a multiple of STAGES, 1 <= STAGES <= N");
        end
    endgenerate

    // Level k holds an operation waiting to have chunk k added.
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] cy;
    logic [STAGES-1:0] md;
    logic [STAGES-1:0] co;
    logic [N-1:0]      op_a [STAGES];
    logic [N-1:0]      op_b [STAGES];
    logic [N-1:0]      ps   [STAGES];
    logic [N-1:0]      nps  [STAGES];
    logic [C-1:0]      cs   [STAGES];
    logic              c_msb;
    logic              adv;

    // One global stall: the whole pipe moves only when the output slot frees up.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            {co[k], cs[k]} = {1'b0, op_a[k][k*C +: C]}
                           + {1'b0, op_b[k][k*C +: C]}
                           + CW'(cy[k]);
            nps[k]            = ps[k];
            nps[k][k*C +: C]  = cs[k];
        end
        // Carry into the MSB recovered from the sum bit: s = a ^ b ^ cin.
        c_msb = nps[STAGES-1][N-1]
              ^ op_a[STAGES-1][N-1]
              ^ op_b[STAGES-1][N-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld       <= '0;
            cy        <= '0;
            md        <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            ovf       <= 1'b0;
            for (int j = 0; j < STAGES; j++) begin
                op_a[j] <= '0;
                op_b[j] <= '0;
                ps[j]   <= '0;
            end
        end else if (adv) begin
            vld[0]    <= in_valid;
            out_valid <= vld[STAGES-1];
            for (int j = 1; j < STAGES; j++) begin
                vld[j] <= vld[j-1];
            end

            if (in_valid) begin
                op_a[0] <= a;
                op_b[0] <= sub ? ~b : b;
                ps[0]   <= '0;
                cy[0]   <= sub | cin;
                md[0]   <= sub;
            end

            for (int j = 1; j < STAGES; j++) begin
                if (vld[j-1]) begin
                    op_a[j] <= op_a[j-1];
                    op_b[j] <= op_b[j-1];
                    ps[j]   <= nps[j-1];
                    cy[j]   <= co[j-1];
                    md[j]   <= md[j-1];
                end
            end

            // In sub mode the final carry is inverted into a borrow flag.
            if (vld[STAGES-1]) begin
                sum <= {co[STAGES-1] ^ md[STAGES-1], nps[STAGES-1]};
                ovf <= co[STAGES-1] ^ c_msb;
            end
        end
    end

endmodule
